// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and the feedback tap offset
// common to the PRBS generator and checker.
package prbs_pkg;

    typedef enum logic [0:0] {
        StSearch = 1'b0,
        StLocked = 1'b1
    } chk_state_e;

    // Second feedback tap of x^ORDER + x^5 + 1.
    localparam int unsigned TAP_OFFSET = 5;

    // Bits needed to hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Sample/status bundle between a PRBS bit source and the PRBS checker.
interface prbs_checker_if #(
    parameter int unsigned CNT_W = 32
);
    logic             i_enable;
    logic             i_valid;
    logic             i_bit;
    logic             i_clear;
    logic             o_lock;
    logic             o_error;
    logic [CNT_W-1:0] o_bit_count;
    logic [CNT_W-1:0] o_err_count;

    modport master (
        output i_enable, i_valid, i_bit, i_clear,
        input  o_lock, o_error, o_bit_count, o_err_count
    );

    modport slave (
        input  i_enable, i_valid, i_bit, i_clear,
        output o_lock, o_error, o_bit_count, o_err_count
    );
endinterface

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module prbs_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign o_count = count_q;
endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises to an x^ORDER + x^5 + 1 sequence, then counts
// compared bits and errors, dropping lock when a window sees too many errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned ORDER    = 9,
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned WINDOW   = 64,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned CNT_W    = 32
) (
    input logic           clock,
    input logic           i_reset,
    prbs_checker_if.slave bus
);
    localparam int unsigned FILL_W  = cnt_width(ORDER);
    localparam int unsigned MATCH_W = cnt_width(LOCK_CNT);
    localparam int unsigned WIN_W   = cnt_width(WINDOW);

    chk_state_e         state_q, state_d;
    logic [ORDER-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic               error_q, error_d;

    logic             sample;
    logic             pred;
    logic             mis;
    logic             bit_inc;
    logic             err_inc;
    logic [WIN_W-1:0] win_err_tot;

    assign sample      = bus.i_enable && bus.i_valid;
    // hist_q[0] is the newest bit, hist_q[ORDER-1] the oldest.
    assign pred        = hist_q[ORDER-1] ^ hist_q[TAP_OFFSET-1];
    assign mis         = pred ^ bus.i_bit;
    assign win_err_tot = win_err_q + WIN_W'(mis);

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        win_err_d = win_err_q;
        error_d   = 1'b0;
        bit_inc   = 1'b0;
        err_inc   = 1'b0;

        if (sample) begin
            unique case (state_q)
                StSearch: begin
                    hist_d = {hist_q[ORDER-2:0], bus.i_bit};
                    if (fill_q < FILL_W'(ORDER)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (mis) begin
                        match_d = '0;
                    end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        match_d   = match_q + MATCH_W'(1);
                        state_d   = StLocked;
                        win_d     = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end

                StLocked: begin
                    // Feeding back the prediction keeps a channel error from
                    // corrupting later predictions.
                    hist_d  = {hist_q[ORDER-2:0], pred};
                    bit_inc = 1'b1;
                    err_inc = mis;
                    error_d = mis;
                    if (win_q == WIN_W'(WINDOW - 1)) begin
                        win_d     = '0;
                        win_err_d = '0;
                        if (win_err_tot >= WIN_W'(LOSS_THR)) begin
                            state_d = StSearch;
                            fill_d  = '0;
                            match_d = '0;
                        end
                    end else begin
                        win_d     = win_q + WIN_W'(1);
                        win_err_d = win_err_tot;
                    end
                end

                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StSearch;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            error_q   <= error_d;
        end
    end

    prbs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_bit_cnt (
        .clock  (clock),
        .i_reset(i_reset),
        .i_clear(bus.i_clear),
        .i_inc  (bit_inc),
        .o_count(bus.o_bit_count)
    );

    prbs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clock  (clock),
        .i_reset(i_reset),
        .i_clear(bus.i_clear),
        .i_inc  (err_inc),
        .o_count(bus.o_err_count)
    );

    assign bus.o_lock  = (state_q == StLocked);
    assign bus.o_error = error_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a queue-based model of
// the lock / window / counter rules, plus directed acquisition and loss cases.
module tb_prbs_checker;
    localparam int unsigned ORDER    = 9;
    localparam int unsigned LOCK_CNT = 32;
    localparam int unsigned WINDOW   = 64;
    localparam int unsigned LOSS_THR = 8;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned TAP      = 5;
    localparam int          CMAX     = (1 << CNT_W) - 1;

    logic clock;
    logic reset;

    prbs_checker_if #(.CNT_W(CNT_W)) bus ();

    prbs_checker #(
        .ORDER   (ORDER),
        .LOCK_CNT(LOCK_CNT),
        .WINDOW  (WINDOW),
        .LOSS_THR(LOSS_THR),
        .CNT_W   (CNT_W)
    ) dut (
        .clock  (clock),
        .i_reset(reset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: history is a queue of the last ORDER bits, oldest first.
    int m_hist[$];
    bit m_locked;
    int m_fill, m_match, m_win, m_werr, m_bits, m_errs;
    bit m_err;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < ORDER; i++) m_hist.push_back(0);
        m_locked = 0;
        m_fill   = 0;
        m_match  = 0;
        m_win    = 0;
        m_werr   = 0;
        m_bits   = 0;
        m_errs   = 0;
        m_err    = 0;
    endtask

    task automatic model_edge(input bit smp, input bit b, input bit clr);
        int pred;
        m_err = 0;
        if (smp) begin
            pred = m_hist[0] ^ m_hist[ORDER - TAP];
            if (!m_locked) begin
                if (m_fill < ORDER) m_fill++;
                else if (b == pred) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1;
                        m_win    = 0;
                        m_werr   = 0;
                    end
                end else m_match = 0;
                m_hist.push_back(b);
            end else begin
                m_hist.push_back(pred);
                if (m_bits < CMAX) m_bits++;
                if (b != pred) begin
                    m_err = 1;
                    m_werr++;
                    if (m_errs < CMAX) m_errs++;
                end
                m_win++;
                if (m_win == WINDOW) begin
                    if (m_werr >= LOSS_THR) begin
                        m_locked = 0;
                        m_fill   = 0;
                        m_match  = 0;
                    end
                    m_win  = 0;
                    m_werr = 0;
                end
            end
            void'(m_hist.pop_front());
        end
        if (clr) begin
            m_bits = 0;
            m_errs = 0;
        end
    endtask

    // Reference generator: plain recurrence b[n] = b[n-9] ^ b[n-5] after the seed.
    int gen_q[$];
    int gen_seed;

    task automatic gen_next(output bit b);
        int n;
        n = gen_q.size();
        if (n < ORDER) b = bit'((gen_seed >> (ORDER - 1 - n)) & 1);
        else b = bit'(gen_q[n - ORDER] ^ gen_q[n - TAP]);
        gen_q.push_back(int'(b));
    endtask

    // Called at a negedge: drive, model the next posedge, check at the next negedge.
    task automatic tick(input bit en, input bit vld, input bit b, input bit clr);
        bus.i_enable = en;
        bus.i_valid  = vld;
        bus.i_bit    = b;
        bus.i_clear  = clr;
        model_edge(en && vld, b, clr);
        @(negedge clock);
        check_val("lock", bus.o_lock, m_locked);
        check_val("error", bus.o_error, m_err);
        check_val("bits", bus.o_bit_count, m_bits);
        check_val("errs", bus.o_err_count, m_errs);
    endtask

    task automatic send(input bit flip);
        bit b;
        gen_next(b);
        tick(1'b1, 1'b1, b ^ flip, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_lock"}, bus.o_lock, 0);
        check_val({tag, "_error"}, bus.o_error, 0);
        check_val({tag, "_bits"}, bus.o_bit_count, 0);
        check_val({tag, "_errs"}, bus.o_err_count, 0);
    endtask

    task automatic do_reset(input int seed);
        reset        = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_bit    = 1'b0;
        bus.i_clear  = 1'b0;
        model_reset();
        gen_q.delete();
        gen_seed = seed;
        #1;
        check_zero("rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic acquire();
        for (int i = 0; i < ORDER + LOCK_CNT; i++) send(1'b0);
    endtask

    initial begin
        int pulses;
        int base;
        bit b;
        bit en, vld, flip, clr;
        int rate;

        reset = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_bit    = 1'b0;
        bus.i_clear  = 1'b0;
        @(negedge clock);

        // Acquisition: lock visible right after the 41st sample, not before.
        do_reset(9'h1FF);
        for (int i = 0; i < ORDER + LOCK_CNT - 1; i++) send(1'b0);
        check_val("acq_early", bus.o_lock, 0);
        send(1'b0);
        check_val("acq_lock", bus.o_lock, 1);
        check_val("acq_bits", bus.o_bit_count, 0);

        // Single error counted once, lock kept.
        for (int i = 0; i < 20; i++) send(1'b0);
        pulses = 0;
        send(1'b1);
        pulses += int'(bus.o_error);
        for (int i = 0; i < 20; i++) begin
            send(1'b0);
            pulses += int'(bus.o_error);
        end
        check_val("single_pulses", pulses, 1);
        check_val("single_errs", bus.o_err_count, 1);
        check_val("single_lock", bus.o_lock, 1);

        // Loss of lock: 8 errors inside the first window.
        do_reset(9'h1FF);
        acquire();
        for (int i = 0; i < WINDOW - 1; i++) send((i % 8) == 0);
        check_val("loss_before", bus.o_lock, 1);
        send(1'b0);
        check_val("loss_after", bus.o_lock, 0);
        check_val("loss_bits", bus.o_bit_count, 64);
        check_val("loss_errs", bus.o_err_count, 8);
        for (int i = 0; i < 20; i++) send(1'b0);
        check_val("loss_hold_bits", bus.o_bit_count, 64);
        check_val("loss_hold_errs", bus.o_err_count, 8);

        // Below threshold: 7 errors in each of 4 windows; bit count saturates.
        do_reset(9'h1FF);
        acquire();
        for (int w = 0; w < 4; w++) begin
            int pos[7];
            for (int k = 0; k < 7; k++) pos[k] = k * 9 + int'($urandom_range(0, 8));
            for (int i = 0; i < WINDOW; i++) begin
                flip = 1'b0;
                for (int k = 0; k < 7; k++) if (pos[k] == i) flip = 1'b1;
                send(flip);
            end
        end
        check_val("thr_lock", bus.o_lock, 1);
        check_val("thr_errs", bus.o_err_count, 28);
        check_val("thr_bits_sat", bus.o_bit_count, (256 > CMAX) ? CMAX : 256);

        // Gaps: valid every other cycle, garbage on invalid cycles.
        do_reset(9'h1FF);
        for (int c = 0; c < 82; c++) begin
            if ((c % 2) == 0) begin
                gen_next(b);
                tick(1'b1, 1'b1, b, 1'b0);
            end else begin
                tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (c == 79) check_val("gap_early", bus.o_lock, 0);
            if (c == 80) check_val("gap_lock", bus.o_lock, 1);
        end

        // All-zero stream satisfies the recurrence.
        do_reset(0);
        acquire();
        check_val("zero_lock", bus.o_lock, 1);

        // Asynchronous reset mid-lock, then clear colliding with an error.
        do_reset(9'h1FF);
        acquire();
        for (int i = 0; i < 10; i++) send(1'b0);
        send(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        gen_q.delete();
        @(negedge clock);
        reset = 1'b1;
        acquire();
        for (int i = 0; i < 10; i++) send(1'b1 * (i == 3));
        gen_next(b);
        tick(1'b1, 1'b1, ~b, 1'b1);
        check_val("clr_error", bus.o_error, 1);
        check_val("clr_bits", bus.o_bit_count, 0);
        check_val("clr_errs", bus.o_err_count, 0);
        check_val("clr_lock", bus.o_lock, 1);

        // Randomised phases with varying error rates, enables and clears.
        do_reset(int'($urandom_range(1, 511)));
        base = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c < 1500) rate = 40;
            else if (c < 2000) rate = 6;
            else if (c < 2500) rate = 0;
            else rate = 40;
            en   = ($urandom_range(0, 9) != 0);
            vld  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 199) == 0);
            flip = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
            if (en && vld) begin
                gen_next(b);
                tick(1'b1, 1'b1, b ^ flip, clr);
                base++;
            end else begin
                tick(en, vld, 1'($urandom_range(0, 1)), clr);
            end
        end
        check_val("rand_samples_nonzero", base > 1000, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter ORDER, default 9: PRBS register length; feedback polynomial x^ORDER + x^5 + 1, identical to the team PRBS generator.
REQ-002 Parameter LOCK_CNT, default 32: consecutive matching bits needed to declare lock.
REQ-003 Parameter WINDOW, default 64: compared-bit window length for loss-of-lock evaluation.
REQ-004 Parameter LOSS_THR, default 8: errors within one window that force loss of lock.
REQ-005 Parameter CNT_W, default 32: width of the bit and error counters.
REQ-006 Port clock, input, 1: single clock; all logic rising-edge.
REQ-007 Port i_reset, input, 1: asynchronous, active-low reset.
REQ-008 Port i_enable, input, 1: block enable.
REQ-009 Port i_valid, input, 1: i_bit is valid this cycle.
REQ-010 Port i_bit, input, 1: received PRBS bit.
REQ-011 Port i_clear, input, 1: synchronous clear of o_bit_count and o_err_count.
REQ-012 Port o_lock, output, 1: checker locked to the sequence.
REQ-013 Port o_error, output, 1: one-cycle pulse, compared bit mismatched.
REQ-014 Port o_bit_count, output, CNT_W: bits compared while locked, saturating.
REQ-015 Port o_err_count, output, CNT_W: mismatches while locked, saturating.

Function
REQ-016 Sample enable: i_bit is sampled only when i_enable && i_valid; otherwise all state holds, and o_error is 0.
REQ-017 Prediction: expected bit b[n] = h[n-ORDER] XOR h[n-5], where h is an ORDER-bit history of the most recent bits.
REQ-018 States: SEARCH (reset state) and LOCKED.
REQ-019 SEARCH, history: every sampled i_bit shifts into the history, and a fill counter increments up to ORDER.
REQ-020 SEARCH, matching: once fill == ORDER, each sample is compared with the prediction; a match increments a match counter, and a mismatch clears it to 0.
REQ-021 SEARCH to LOCKED: when the match counter reaches LOCK_CNT, the state moves to LOCKED and o_lock rises the following cycle.
REQ-022 LOCKED, history: the predicted bit (not i_bit) shifts into the history, so one channel error is counted exactly once.
REQ-023 LOCKED, counting: each sample increments o_bit_count; a mismatch also increments o_err_count and pulses o_error in the cycle after sampling.
REQ-024 Window tracking: in LOCKED, a window counter counts samples 1..WINDOW, and a window error counter counts mismatches.
REQ-025 Window end: on the WINDOW-th sample, if window errors (including this sample) >= LOSS_THR, the state moves to SEARCH; otherwise both window counters restart.
REQ-026 Entering SEARCH: o_lock drops, fill, match and window counters clear, and o_bit_count and o_err_count hold their values.
REQ-027 Counter saturation: both counters saturate at 2^CNT_W-1 and never wrap.
REQ-028 i_clear priority: i_clear zeroes both counters and overrides any same-cycle increment; it does not affect state or history.
REQ-029 All-zero stream: an all-zero input satisfies the recurrence and SHALL lock, matching the generator's zero-seed output.

Reset
REQ-030 While i_reset is low: state SEARCH, history, all counters and all outputs are 0; this holds even mid-lock.
REQ-031 Reset release: operation starts at the first rising clock edge with i_reset high.

Structure
REQ-032 Shared package prbs_pkg holds the state encoding (SEARCH, LOCKED) and the constant TAP_OFFSET = 5, which the generator also uses.
REQ-033 A sub-module prbs_sat_counter (CNT_W-wide, with increment, clear and saturation) SHALL implement o_bit_count and o_err_count.

Verification
REQ-034 Acquisition: generator with ORDER=9, seed 9'h1FF, valid every cycle -> o_lock rises the cycle after the 41st sample (9 fill + 32 matches).
REQ-035 Single error: while locked, flip one bit -> exactly one o_error pulse, o_err_count = 1, o_lock stays 1.
REQ-036 Loss of lock: inject 8 flips within one 64-bit window -> o_lock drops after that window's 64th sample; counters retain their values.
REQ-037 No loss below threshold: inject 7 flips per window for 4 windows -> o_lock stays 1 and o_err_count = 28.
REQ-038 Gaps: toggle i_valid 1/0 alternately -> lock after 41 valid samples (82 cycles); invalid cycles change nothing.
REQ-039 Mid-lock reset and clear: assert i_reset while locked -> all outputs 0 asynchronously; assert i_clear together with an error -> both counts read 0.
